// File: rtl/ttl_multi_output.sv
// Timed TTL output bank: events queue in a FIFO and are applied on fire as sub-cycle edges in SER_W-bit words.
// Define TTL_PULSE_MODE_EN to add the pulse FSM that restores prior levels after ev_len cycles.
module ttl_multi_output #(
   parameter int NUM_CH     = 8,
   parameter int SER_W      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      ev_valid,
   output logic                      ev_ready,
   input  logic [NUM_CH-1:0]         ev_mask,
   input  logic [NUM_CH-1:0]         ev_level,
   input  logic [$clog2(SER_W)-1:0]  ev_fine,
   input  logic                      ev_pulse,
   input  logic [LEN_W-1:0]          ev_len,
   input  logic                      fire,
   input  logic                      override_en,
   input  logic [NUM_CH-1:0]         override_value,
   input  logic                      err_clr,
   output logic [NUM_CH*SER_W-1:0]   ser_word,
   output logic [NUM_CH-1:0]         level_out,
   output logic                      fifo_empty,
   output logic                      fifo_full,
   output logic                      busy,
   output logic                      underflow_err
);

   localparam int FW = $clog2(SER_W);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TTL_PULSE_MODE_EN
   localparam int EW = 2*NUM_CH + FW + 1 + LEN_W;
`else
   localparam int EW = 2*NUM_CH + FW;
`endif

   logic [EW-1:0]           r_mem [FIFO_DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [AW:0]             r_count;
   logic [NUM_CH-1:0]       r_level;
   logic [NUM_CH*SER_W-1:0] r_ser_word;
   logic                    r_underflow;

   logic                    w_push;
   logic                    w_pop;
   logic [EW-1:0]           w_push_dat;
   logic [EW-1:0]           w_head;
   logic [NUM_CH-1:0]       w_head_mask;
   logic [NUM_CH-1:0]       w_head_level;
   logic [FW-1:0]           w_head_fine;
   logic [NUM_CH-1:0]       w_edge_mask;
   logic [FW-1:0]           w_edge_fine;
   logic [NUM_CH-1:0]       w_level_nxt;
   logic [NUM_CH*SER_W-1:0] w_word_nxt;

   assign fifo_empty = (r_count == '0);
   assign fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   // Held low during reset so nothing is queued while the block is being cleared.
   assign ev_ready   = resetn && !fifo_full;
   assign w_push     = ev_valid && ev_ready;
   assign w_pop      = fire && !fifo_empty;

   assign w_head       = r_mem[r_rd_ptr];
   assign w_head_mask  = w_head[EW-1 -: NUM_CH];
   assign w_head_level = w_head[EW-NUM_CH-1 -: NUM_CH];
   assign w_head_fine  = w_head[EW-2*NUM_CH-1 -: FW];

`ifdef TTL_PULSE_MODE_EN
   typedef enum logic {IDLE, PULSE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  w_cnt_nxt;
   logic [NUM_CH-1:0] r_saved;
   logic [NUM_CH-1:0] w_saved_nxt;
   logic [NUM_CH-1:0] r_pmask;
   logic [NUM_CH-1:0] w_pmask_nxt;
   logic [FW-1:0]     r_pfine;
   logic [FW-1:0]     w_pfine_nxt;
   logic              w_restore;
   logic              w_head_pulse;
   logic [LEN_W-1:0]  w_head_len;

   assign w_push_dat   = {ev_mask, ev_level, ev_fine, ev_pulse, ev_len};
   assign w_head_pulse = w_head[LEN_W];
   assign w_head_len   = w_head[LEN_W-1:0];
   assign busy         = (r_state == PULSE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_saved <= '0;
         r_pmask <= '0;
         r_pfine <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_saved <= w_saved_nxt;
         r_pmask <= w_pmask_nxt;
         r_pfine <= w_pfine_nxt;
      end
   end

   // A fresh event always beats a pending restore, which is how a mid-pulse fire cancels it.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_saved_nxt = r_saved;
      w_pmask_nxt = r_pmask;
      w_pfine_nxt = r_pfine;
      w_restore   = 1'b0;
      if (w_pop) begin
         if (w_head_pulse) begin
            w_state_nxt = PULSE;
            w_cnt_nxt   = (w_head_len == '0) ? LEN_W'(1) : w_head_len;
            w_saved_nxt = r_level;
            w_pmask_nxt = w_head_mask;
            w_pfine_nxt = w_head_fine;
         end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      end else begin
         case (r_state)
            PULSE: begin
               if (r_cnt <= LEN_W'(1)) begin
                  w_restore   = 1'b1;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
`else
   logic w_unused_pulse;

   assign w_push_dat     = {ev_mask, ev_level, ev_fine};
   assign w_unused_pulse = ev_pulse ^ (^ev_len);
   assign busy           = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_dat;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Bits below the fine position still carry the pre-edge level; the rest carry the new one.
   always_comb begin
      w_edge_mask = '0;
      w_edge_fine = '0;
      w_level_nxt = r_level;
      if (w_pop) begin
         w_edge_mask = w_head_mask;
         w_edge_fine = w_head_fine;
         w_level_nxt = (r_level & ~w_head_mask) | (w_head_level & w_head_mask);
      end
`ifdef TTL_PULSE_MODE_EN
      else if (w_restore) begin
         w_edge_mask = r_pmask;
         w_edge_fine = r_pfine;
         w_level_nxt = (r_level & ~r_pmask) | (r_saved & r_pmask);
      end
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         for (int j = 0; j < SER_W; j++) begin
            if (override_en)
               w_word_nxt[i*SER_W+j] = override_value[i];
            else if (w_edge_mask[i] && (FW'(j) < w_edge_fine))
               w_word_nxt[i*SER_W+j] = r_level[i];
            else
               w_word_nxt[i*SER_W+j] = w_level_nxt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_level     <= '0;
         r_ser_word  <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_level    <= w_level_nxt;
         r_ser_word <= w_word_nxt;
         if (fire && fifo_empty)
            r_underflow <= 1'b1;
         else if (err_clr)
            r_underflow <= 1'b0;
      end
   end

   assign ser_word      = r_ser_word;
   assign level_out     = r_level;
   assign underflow_err = r_underflow;

endmodule

// File: tb/tb_ttl_multi_output.sv
// Directed bench for ttl_multi_output with default parameters; expectations follow TTL_PULSE_MODE_EN.
module tb_ttl_multi_output;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ev_valid;
   logic        ev_ready;
   logic [7:0]  ev_mask;
   logic [7:0]  ev_level;
   logic [2:0]  ev_fine;
   logic        ev_pulse;
   logic [15:0] ev_len;
   logic        fire;
   logic        override_en;
   logic [7:0]  override_value;
   logic        err_clr;
   logic [63:0] ser_word;
   logic [7:0]  level_out;
   logic        fifo_empty;
   logic        fifo_full;
   logic        busy;
   logic        underflow_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ttl_multi_output dut (
      .clk(clk), .resetn(resetn),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mask(ev_mask), .ev_level(ev_level),
      .ev_fine(ev_fine), .ev_pulse(ev_pulse), .ev_len(ev_len),
      .fire(fire), .override_en(override_en), .override_value(override_value), .err_clr(err_clr),
      .ser_word(ser_word), .level_out(level_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .busy(busy), .underflow_err(underflow_err)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ev(input logic [7:0] m, input logic [7:0] l, input logic [2:0] f,
                         input logic p, input logic [15:0] n);
      ev_mask = m; ev_level = l; ev_fine = f; ev_pulse = p; ev_len = n;
   endtask

   task automatic push(input logic [7:0] m, input logic [7:0] l, input logic [2:0] f,
                       input logic p, input logic [15:0] n);
      set_ev(m, l, f, p, n);
      ev_valid = 1'b1;
      step();
      ev_valid = 1'b0;
   endtask

   task automatic fire_once();
      fire = 1'b1;
      step();
      fire = 1'b0;
   endtask

   logic        pulse_on;
   logic [7:0]  exp_lvl;

   initial begin
`ifdef TTL_PULSE_MODE_EN
      pulse_on = 1'b1;
`else
      pulse_on = 1'b0;
`endif
      resetn = 1'b0; ev_valid = 1'b0; fire = 1'b0; override_en = 1'b0;
      override_value = '0; err_clr = 1'b0;
      set_ev(8'h00, 8'h00, 3'd0, 1'b0, 16'd0);
      step(); step();
      chk("rst_ser_word", ser_word, 64'h0);
      chk("rst_level", level_out, 8'h00);
      chk("rst_err", underflow_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_ready", ev_ready, 1'b0);
      resetn = 1'b1;
      step();
      chk("ready_after_rst", ev_ready, 1'b1);

      // fine edge on ch0
      push(8'h01, 8'h01, 3'd3, 1'b0, 16'd0);
      chk("queued_not_empty", fifo_empty, 1'b0);
      fire_once();
      chk("fine_edge_word", ser_word, 64'h0000_0000_0000_00F8);
      chk("fine_edge_level", level_out, 8'h01);
      step();
      chk("steady_word", ser_word, 64'h0000_0000_0000_00FF);
      chk("drained", fifo_empty, 1'b1);

      // underflow
      fire_once();
      chk("uflow_set", underflow_err, 1'b1);
      chk("uflow_word", ser_word, 64'h0000_0000_0000_00FF);
      chk("uflow_level", level_out, 8'h01);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("uflow_clr", underflow_err, 1'b0);
      fire = 1'b1; err_clr = 1'b1; step(); fire = 1'b0; err_clr = 1'b0;
      chk("uflow_set_wins", underflow_err, 1'b1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("uflow_clr2", underflow_err, 1'b0);

      // fill to full, refused 17th, pop while offering
      ev_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         set_ev(8'h80, (k % 2 == 0) ? 8'h80 : 8'h00, 3'd0, 1'b0, 16'd0);
         step();
      end
      chk("full_flag", fifo_full, 1'b1);
      chk("full_ready", ev_ready, 1'b0);
      set_ev(8'h40, 8'h40, 3'd0, 1'b0, 16'd0);
      step();
      chk("full_refuse", fifo_full, 1'b1);
      fire = 1'b1; step(); fire = 1'b0; ev_valid = 1'b0;
      chk("pop_full_clear", fifo_full, 1'b0);
      chk("pop_ready", ev_ready, 1'b1);
      chk("pop_level", level_out, 8'h81);
      chk("pop_word", ser_word, 64'hFF00_0000_0000_00FF);
      fire = 1'b1;
      for (int k = 0; k < 14; k++) step();
      fire = 1'b0;
      chk("one_left", fifo_empty, 1'b0);
      fire_once();
      chk("count15_empty", fifo_empty, 1'b1);
      chk("last_level", level_out, 8'h01);
      chk("last_word", ser_word, 64'h0000_0000_0000_00FF);

      // pulse len=4 on ch1
      push(8'h02, 8'h02, 3'd0, 1'b1, 16'd4);
      fire_once();
      for (int k = 0; k < 4; k++) begin
         chk("pulse_word", ser_word, 64'h0000_0000_0000_FFFF);
         chk("pulse_busy", busy, pulse_on);
         step();
      end
      chk("pulse_end_word", ser_word, pulse_on ? 64'h0000_0000_0000_00FF : 64'h0000_0000_0000_FFFF);
      chk("pulse_end_busy", busy, 1'b0);
      exp_lvl = pulse_on ? 8'h01 : 8'h03;
      chk("pulse_end_level", level_out, exp_lvl);

      // len=0 acts as 1, restore at fine=2
      push(8'h02, 8'h02, 3'd2, 1'b1, 16'd0);
      fire_once();
      chk("p0_word", ser_word, pulse_on ? 64'h0000_0000_0000_FCFF : 64'h0000_0000_0000_FFFF);
      chk("p0_busy", busy, pulse_on);
      step();
      chk("p0_restore", ser_word, pulse_on ? 64'h0000_0000_0000_03FF : 64'h0000_0000_0000_FFFF);
      chk("p0_busy_end", busy, 1'b0);
      step();
      chk("p0_settled", ser_word, pulse_on ? 64'h0000_0000_0000_00FF : 64'h0000_0000_0000_FFFF);

      // override
      override_en = 1'b1; override_value = 8'hAA;
      push(8'h01, 8'h00, 3'd0, 1'b0, 16'd0);
      chk("ovr_word", ser_word, 64'hFF00_FF00_FF00_FF00);
      fire_once();
      chk("ovr_word_fire", ser_word, 64'hFF00_FF00_FF00_FF00);
      exp_lvl = pulse_on ? 8'h00 : 8'h02;
      chk("ovr_level", level_out, exp_lvl);
      override_en = 1'b0;
      step();
      chk("ovr_release", ser_word, pulse_on ? 64'h0 : 64'h0000_0000_0000_FF00);

      // reset mid-pulse with queued events
      push(8'h04, 8'h04, 3'd0, 1'b0, 16'd0);
      fire_once();
      ev_valid = 1'b1;
      set_ev(8'h04, 8'h00, 3'd0, 1'b1, 16'd10); step();
      set_ev(8'h08, 8'h08, 3'd0, 1'b0, 16'd0);  step(); step(); step();
      ev_valid = 1'b0;
      fire_once();
      chk("mid_busy", busy, pulse_on);
      exp_lvl = pulse_on ? 8'h00 : 8'h02;
      chk("mid_level", level_out, exp_lvl);
      resetn = 1'b0;
      step();
      chk("mid_rst_word", ser_word, 64'h0);
      chk("mid_rst_level", level_out, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_empty", fifo_empty, 1'b1);
      chk("mid_rst_ready", ev_ready, 1'b0);
      resetn = 1'b1;
      for (int k = 0; k < 12; k++) step();
      chk("no_restore_word", ser_word, 64'h0);
      chk("no_restore_level", level_out, 8'h00);
      chk("no_restore_busy", busy, 1'b0);
      chk("post_rst_empty", fifo_empty, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ttl_multi_output.md
TTL_MULTI_OUTPUT -- requirements
Module: ttl_multi_output

Interface
REQ-001 The block SHALL have these parameters: NUM_CH, default 8, number of TTL channels; SER_W, default 8, serializer bits per clk cycle; FIFO_DEPTH, default 16, event FIFO entries (power of 2); LEN_W, default 16, pulse-length counter width.
REQ-002 The block SHALL have these ports: clk  in  1  fabric clock, all logic on rising edge; resetn  in  1  synchronous active-low reset.
REQ-003 The block SHALL have these ports: ev_valid  in  1, event offer; ev_ready  out  1, event accept; ev_mask  in  NUM_CH, channels affected; ev_level  in  NUM_CH, new level per channel; ev_fine  in  clog2(SER_W), sub-cycle edge position; ev_pulse  in  1, 1 = pulse mode; ev_len  in  LEN_W, pulse length in clk cycles.
REQ-004 The block SHALL have these ports: fire  in  1, timestamp match that pops and applies the FIFO head; override_en  in  1; override_value  in  NUM_CH; err_clr  in  1.
REQ-005 The block SHALL have these ports: ser_word  out  NUM_CH*SER_W, channel i word at bits [i*SER_W +: SER_W], bit 0 sent first; level_out  out  NUM_CH, tracked level; fifo_empty, fifo_full, busy, underflow_err  out  1 each.

Function
REQ-006 The block SHALL assert ev_ready = !fifo_full and push {mask, level, fine, pulse, len} on ev_valid && ev_ready.
REQ-007 The block SHALL keep the FIFO count unchanged on a simultaneous push and pop, and SHALL accept the push when the FIFO is full and fire pops in the same cycle only if ev_ready was high, i.e. never.
REQ-008 On fire with a non-empty FIFO, the block SHALL pop the head and apply it; ser_word and level_out SHALL update on the next clk edge (1-cycle latency).
REQ-009 For each masked channel, ser_word bits [fine-1:0] SHALL hold the old level, bits [SER_W-1:fine] SHALL take the new level, and level_out SHALL become the new level; unmasked channels SHALL be unchanged.
REQ-010 In cycles without an applied edge, each channel word SHALL be {SER_W{level_out[i]}}.
REQ-011 On fire with an empty FIFO, the block SHALL set underflow_err (sticky) and change no output; err_clr SHALL clear it, and set SHALL win over a simultaneous err_clr.
REQ-012 The pulse FSM SHALL have the states IDLE and PULSE; an applied event with ev_pulse = 1 SHALL save the prior levels of masked channels, load the counter with max(ev_len, 1), and enter PULSE.
REQ-013 In PULSE, the counter SHALL decrement each cycle; on reaching 0, the saved levels SHALL be restored at the same fine position on masked channels, and the FSM SHALL return to IDLE.
REQ-014 busy SHALL equal (state == PULSE).
REQ-015 A fire applied during PULSE SHALL cancel the pending restore, apply the new event, and re-enter PULSE or go to IDLE according to its ev_pulse bit.
REQ-016 While override_en = 1, ser_word SHALL equal {SER_W{override_value[i]}} per channel from the next cycle; the FIFO, the FSM and level_out SHALL keep operating.
REQ-017 On release of override_en, the output SHALL revert to the tracked level the next cycle.

Reset
REQ-018 While resetn = 0 at a clk edge, the block SHALL empty the FIFO, set the FSM to IDLE, and clear the counter.
REQ-019 On the same reset, the block SHALL drive ser_word = 0, level_out = 0, underflow_err = 0, busy = 0, fifo_empty = 1, fifo_full = 0, ev_ready = 0 during reset.
REQ-020 A reset asserted mid-pulse SHALL discard the pending restore.

Configuration
REQ-021 With TTL_PULSE_MODE_EN defined, the block SHALL implement the pulse FSM, counter and saved levels per REQ-012..015.
REQ-022 Without TTL_PULSE_MODE_EN, the block SHALL ignore ev_pulse and ev_len (not stored in the FIFO), hold busy = 0, and treat every event as a level event.

Verification
REQ-023 The bench SHALL cover: push mask=0x01, level=0x01, fine=3, then fire -> next cycle ch0 word = 8'b1111_1000, level_out[0] = 1, then 8'hFF.
REQ-024 The bench SHALL cover: push 16 events -> fifo_full = 1, ev_ready = 0; 17th offer not accepted; fire -> count 15, ev_ready = 1.
REQ-025 The bench SHALL cover: fire on empty -> underflow_err = 1, outputs unchanged; err_clr -> 0.
REQ-026 The bench SHALL cover: pulse event mask=0x02, level=1, fine=0, len=4 -> ch1 = 8'hFF for 4 cycles, then restored to 8'h00, busy high for those 4 cycles; with the macro off -> ch1 stays 8'hFF and busy = 0.
REQ-027 The bench SHALL cover: override_en = 1, override_value = 0xAA, then a fire -> ser_word channels alternate 00/FF, level_out updates; release -> tracked levels appear.
REQ-028 The bench SHALL cover: resetn = 0 during PULSE with 3 events queued -> all outputs 0, fifo_empty = 1, no restore afterward.
